// File: rtl/timer_event_capture.sv
// Timestamps rising edges of the two timer comparator outputs into a small FIFO
// drained over valid/ready, with per-channel saturating counters and a sticky overflow.
module timer_event_capture #(
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             cmp0_in,
  input  logic                             cmp1_in,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [TS_WIDTH+1:0]              evt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [CNT_WIDTH-1:0]             evt_count0,
  output logic [CNT_WIDTH-1:0]             evt_count1,
  input  logic                             clear_counts,
  output logic                             overflow,
  input  logic                             clear_overflow,
  output logic                             irq
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0]     FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [1:0]          s1, s2, s3;
  logic [1:0]          edges;
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH+1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic                full, push, pop, write;

  // s1/s2 form the metastability guard; s3 only remembers the previous s2 for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
      s3 <= 2'b00;
    end else begin
      s1 <= {cmp1_in, cmp0_in};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edges = s2 & ~s3 & {2{enable}};

  always_ff @(posedge clk) begin
    if (rst)
      ts <= '0;
    else if (enable)
      ts <= ts + TS_WIDTH'(1);
  end

  assign evt_valid = (fifo_level != '0);
  assign full      = (fifo_level == FULL_LEVEL);
  assign push      = |edges;
  assign pop       = evt_valid & evt_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept the new entry
  assign write     = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (write)
      mem[wr_ptr] <= {edges, ts};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (write)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({write, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign evt_data = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (push & full & ~pop)
      overflow <= 1'b1;
    else if (clear_overflow)
      overflow <= 1'b0;
  end

  // Counters keep counting even when the FIFO drops the entry
  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      evt_count0 <= '0;
      evt_count1 <= '0;
    end else begin
      if (edges[0] && evt_count0 != CNT_MAX)
        evt_count0 <= evt_count0 + CNT_WIDTH'(1);
      if (edges[1] && evt_count1 != CNT_MAX)
        evt_count1 <= evt_count1 + CNT_WIDTH'(1);
    end
  end

  assign irq = evt_valid | overflow;

endmodule

// File: tb/tb_timer_event_capture.sv
// Self-checking bench for timer_event_capture: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model.
module tb_timer_event_capture;

  localparam int TSW   = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic            clk = 1'b0;
  logic            rst, enable, cmp0_in, cmp1_in, evt_ready, clear_counts, clear_overflow;
  logic            evt_valid, overflow, irq;
  logic [TSW+1:0]  evt_data;
  logic [3:0]      fifo_level;
  logic [CW-1:0]   evt_count0, evt_count1;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [TSW+1:0] q[$];
  int             ts_m;
  logic [1:0]     hist[3];
  int             c0_m, c1_m;
  bit             ov_m;

  timer_event_capture #(.TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmp0_in(cmp0_in), .cmp1_in(cmp1_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .fifo_level(fifo_level), .evt_count0(evt_count0), .evt_count1(evt_count1),
    .clear_counts(clear_counts), .overflow(overflow), .clear_overflow(clear_overflow),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // One clock: advance the model from the inputs held before the edge, then sample #1 after
  task automatic tick();
    logic [1:0] e;
    bit         popd;
    int         sz;
    if (rst) begin
      q.delete();
      ts_m = 0;
      hist[0] = 2'b00; hist[1] = 2'b00; hist[2] = 2'b00;
      c0_m = 0; c1_m = 0; ov_m = 0;
    end else begin
      sz   = q.size();
      e    = hist[1] & ~hist[2] & {2{enable}};
      popd = (sz > 0) && evt_ready;
      if (popd) void'(q.pop_front());
      if (e != 2'b00 && (sz < DEPTH || popd))
        q.push_back({e, ts_m[TSW-1:0]});
      if (e != 2'b00 && sz >= DEPTH && !popd) ov_m = 1;
      else if (clear_overflow) ov_m = 0;
      if (clear_counts) begin
        c0_m = 0; c1_m = 0;
      end else begin
        if (e[0] && c0_m < 255) c0_m++;
        if (e[1] && c1_m < 255) c1_m++;
      end
      if (enable) ts_m = (ts_m + 1) % 65536;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {cmp1_in, cmp0_in};
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] exp_state();
    logic           v;
    logic [TSW+1:0] d;
    v = (q.size() != 0);
    d = v ? q[0] : '0;
    return {v, d, 4'(q.size()), 8'(c0_m), 8'(c1_m), ov_m, v | ov_m};
  endfunction

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; cmp0_in = 1'b0; cmp1_in = 1'b0;
    evt_ready = 1'b0; clear_counts = 1'b0; clear_overflow = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || evt_data !== '0 || fifo_level !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_fifo: got valid=%b data=%h level=%0d expected 0/0/0",
               evt_valid, evt_data, fifo_level);
    end
    n_checks++;
    if (evt_count0 !== 8'd0 || evt_count1 !== 8'd0 || overflow !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got c0=%0d c1=%0d ov=%b irq=%b expected all 0",
               evt_count0, evt_count1, overflow, irq);
    end
  endtask

  task automatic test_first_event();
    do_reset();
    for (int i = 1; i <= 9; i++) tick();
    cmp0_in = 1'b1;
    tick();
    tick();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL first_early_valid: got %b expected 0", evt_valid);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_data !== {2'b01, 16'd11}) begin
      n_fail++;
      $display("[TB] FAIL first_event: got valid=%b data=%h expected 1/%h",
               evt_valid, evt_data, {2'b01, 16'd11});
    end
    n_checks++;
    if (evt_count0 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL first_count0: got %0d expected 1", evt_count0);
    end
    cmp0_in = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    cmp0_in = 1'b1; cmp1_in = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (fifo_level !== 4'd1 || evt_data[17:16] !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL simul_entry: got level=%0d src=%b expected 1/11",
               fifo_level, evt_data[17:16]);
    end
    n_checks++;
    if (evt_count0 !== 8'd1 || evt_count1 !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL simul_counts: got c0=%0d c1=%0d expected 1/1", evt_count0, evt_count1);
    end
    cmp0_in = 1'b0; cmp1_in = 1'b0;
  endtask

  task automatic test_overflow();
    int prev_ts;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cmp1_in = 1'b1; tick();
      cmp1_in = 1'b0; tick();
    end
    tick(); tick(); tick();
    n_checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || irq !== 1'b1 || evt_count1 !== 8'd9) begin
      n_fail++;
      $display("[TB] FAIL ovf_state: got level=%0d ov=%b irq=%b c1=%0d expected 8/1/1/9",
               fifo_level, overflow, irq, evt_count1);
    end
    evt_ready = 1'b1;
    prev_ts = -1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_data !== q[0] || int'(evt_data[15:0]) <= prev_ts) begin
        n_fail++;
        $display("[TB] FAIL ovf_drain%0d: got valid=%b data=%h expected 1/%h after ts %0d",
                 i, evt_valid, evt_data, q[0], prev_ts);
      end
      prev_ts = int'(evt_data[15:0]);
      tick();
    end
    evt_ready = 1'b0;
    n_checks++;
    if (fifo_level !== 4'd0 || irq !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovf_drained: got level=%0d irq=%b expected 0/1", fifo_level, irq);
    end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_clear: got irq=%b ov=%b expected 0/0", irq, overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cmp1_in = 1'b1; tick();
      cmp1_in = 1'b0; tick();
    end
    tick(); tick(); tick();
    cmp0_in = 1'b1;
    tick(); tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0; cmp0_in = 1'b0;
    n_checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b0 || evt_data !== q[0]) begin
      n_fail++;
      $display("[TB] FAIL fullpop_state: got level=%0d ov=%b head=%h expected 8/0/%h",
               fifo_level, overflow, evt_data, q[0]);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (evt_data !== q[0] || (i == 7 && evt_data[17:16] !== 2'b01)) begin
        n_fail++;
        $display("[TB] FAIL fullpop_drain%0d: got %h expected %h", i, evt_data, q[0]);
      end
      tick();
    end
    evt_ready = 1'b0;
    // Refill, then let an overflowing push coincide with clear_overflow
    for (int i = 0; i < 8; i++) begin
      cmp1_in = 1'b1; tick();
      cmp1_in = 1'b0; tick();
    end
    tick(); tick(); tick();
    cmp0_in = 1'b1;
    tick(); tick();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0; cmp0_in = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL set_beats_clear: got ov=%b level=%0d expected 1/8", overflow, fifo_level);
    end
  endtask

  task automatic test_enable_hold();
    int hold;
    do_reset();
    evt_ready = 1'b1;
    tick(); tick(); tick();
    hold = ts_m;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cmp0_in = ~cmp0_in;
      tick();
    end
    cmp0_in = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (fifo_level !== 4'd0 || evt_count0 !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL disabled_hold: got level=%0d c0=%0d expected 0/0", fifo_level, evt_count0);
    end
    enable = 1'b1; cmp0_in = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_data !== {2'b01, 16'(hold + 2)}) begin
      n_fail++;
      $display("[TB] FAIL resume_ts: got valid=%b data=%h expected 1/%h",
               evt_valid, evt_data, {2'b01, 16'(hold + 2)});
    end
    cmp0_in = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cmp0_in = 1'b1; tick();
      cmp0_in = 1'b0; tick();
    end
    tick(); tick(); tick();
    n_checks++;
    if (evt_count0 !== 8'hFF) begin
      n_fail++;
      $display("[TB] FAIL saturate: got %0d expected 255", evt_count0);
    end
    cmp0_in = 1'b1;
    tick(); tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0; cmp0_in = 1'b0;
    n_checks++;
    if (evt_count0 !== 8'd0 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clear_beats_edge: got c0=%0d valid=%b expected 0/1", evt_count0, evt_valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 65540; i++) tick();
    cmp0_in = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (evt_data !== {2'b01, 16'd6}) begin
      n_fail++;
      $display("[TB] FAIL wrap_ts: got %h expected %h", evt_data, {2'b01, 16'd6});
    end
    for (int i = 0; i < 2; i++) begin
      cmp0_in = 1'b0; tick();
      cmp0_in = 1'b1; tick();
    end
    tick(); tick();
    n_checks++;
    if (fifo_level !== 4'd3) begin
      n_fail++;
      $display("[TB] FAIL wrap_queued: got %0d expected 3", fifo_level);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({evt_valid, evt_data, fifo_level, evt_count0, evt_count1, overflow, irq} !== 41'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset: got valid=%b data=%h level=%0d c0=%0d irq=%b expected all 0",
               evt_valid, evt_data, fifo_level, evt_count0, irq);
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (evt_count0 !== 8'd1 || fifo_level !== 4'd1 || evt_data[15:0] !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL stale_level: got c0=%0d level=%0d ts=%0d expected 1/1/2",
               evt_count0, fifo_level, evt_data[15:0]);
    end
    cmp0_in = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rst            = ($urandom_range(0, 599) == 0);
      enable         = ($urandom_range(0, 7) != 0);
      cmp0_in        = ($urandom_range(0, 2) == 0);
      cmp1_in        = ($urandom_range(0, 3) == 0);
      evt_ready      = ((i / 250) % 2 == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      clear_counts   = ($urandom_range(0, 79) == 0);
      clear_overflow = ($urandom_range(0, 29) == 0);
      tick();
      n_checks++;
      if ({evt_valid, evt_data, fifo_level, evt_count0, evt_count1, overflow, irq} !== exp_state()) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", i,
                 {evt_valid, evt_data, fifo_level, evt_count0, evt_count1, overflow, irq}, exp_state());
      end
    end
    rst = 1'b0; clear_counts = 1'b0; clear_overflow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_enable_hold();
    test_saturation();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
